// File: rtl/collatz_pkg.sv
// Shared types for the Collatz iterator: FSM states and result status codes.
package collatz_pkg;

    typedef enum logic [1:0] {
        StatusOk       = 2'd0,
        StatusOverflow = 2'd1,
        StatusZero     = 2'd2,
        StatusTimeout  = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_step_w.sv
// Single combinational Collatz step: halve even values, 3n+1 odd values with overflow detect.
module collatz_step_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] next_o,
    output logic             ovf_o
);

    logic [WIDTH+1:0] triple;

    always_comb begin
        // 3n+1 as 2n + n + 1, two guard bits catch results >= 2^WIDTH
        triple = {1'b0, cur_i, 1'b0} + {2'b00, cur_i} + {{(WIDTH+1){1'b0}}, 1'b1};
        next_o = cur_i[0] ? triple[WIDTH-1:0] : {1'b0, cur_i[WIDTH-1:1]};
        ovf_o  = cur_i[0] & (|triple[WIDTH+1:WIDTH]);
    end

endmodule

// File: rtl/collatz_runner.sv
// Iterates the Collatz step from a start value until it reaches 1, overflows or times out,
// then holds steps/peak/status behind a valid/ready result port.
module collatz_runner
    import collatz_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  start_value,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [STEP_W-1:0] steps,
    output logic [WIDTH-1:0]  peak,
    output logic [1:0]        status,
    output logic              busy
);

    localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_STEPS);
    localparam logic [WIDTH-1:0]  ValOne   = WIDTH'(1);

    state_t            state_q;
    status_t           status_q;
    logic [WIDTH-1:0]  cur_q;
    logic [WIDTH-1:0]  peak_q;
    logic [STEP_W-1:0] steps_q;
    logic              start_ready_q;
    logic              result_valid_q;
    logic              busy_q;

    logic [WIDTH-1:0]  step_next;
    logic              step_ovf;
    logic [STEP_W-1:0] steps_d;

    collatz_step_w #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur_i (cur_q),
        .next_o(step_next),
        .ovf_o (step_ovf)
    );

    assign steps_d = steps_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            status_q       <= StatusOk;
            cur_q          <= '0;
            peak_q         <= '0;
            steps_q        <= '0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        start_ready_q <= 1'b0;
                        steps_q       <= '0;
                        status_q      <= StatusOk;
                        cur_q         <= start_value;
                        peak_q        <= start_value;
                        // 0 and 1 resolve without iterating
                        if (start_value == '0) begin
                            status_q       <= StatusZero;
                            result_valid_q <= 1'b1;
                            state_q        <= StDone;
                        end else if (start_value == ValOne) begin
                            result_valid_q <= 1'b1;
                            state_q        <= StDone;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (step_ovf) begin
                        // cur/steps/peak keep the last in-range value
                        status_q       <= StatusOverflow;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        state_q        <= StDone;
                    end else begin
                        cur_q   <= step_next;
                        steps_q <= steps_d;
                        if (step_next > peak_q) begin
                            peak_q <= step_next;
                        end
                        if (step_next == ValOne) begin
                            status_q       <= StatusOk;
                            busy_q         <= 1'b0;
                            result_valid_q <= 1'b1;
                            state_q        <= StDone;
                        end else if (steps_d == MaxSteps) begin
                            status_q       <= StatusTimeout;
                            busy_q         <= 1'b0;
                            result_valid_q <= 1'b1;
                            state_q        <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    start_ready_q  <= 1'b1;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign steps        = steps_q;
    assign peak         = peak_q;
    assign status       = status_q;

    a_ready_valid_excl: assert property (@(posedge clock) disable iff (!reset_n)
        !(start_ready && result_valid));

    a_busy_run: assert property (@(posedge clock) disable iff (!reset_n)
        busy == (state_q == StRun));

    a_result_held: assert property (@(posedge clock) disable iff (!reset_n)
        (result_valid && !result_ready) |=> ($stable(steps) && $stable(peak) && $stable(status)));

endmodule

// File: tb/tb_collatz_runner.sv
// Randomized and directed checks of collatz_runner against a plain-arithmetic Collatz model.
module tb_collatz_runner;

    localparam int unsigned W     = 8;
    localparam int unsigned Limit = 1 << W;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    // Unit 0 uses MAX_STEPS=255, unit 1 uses MAX_STEPS=5.
    logic       sv   [2];
    logic [7:0] sval [2];
    logic       rr   [2];
    logic       sr   [2];
    logic       rv   [2];
    logic       bz   [2];
    logic [7:0] st_o [2];
    logic [7:0] pk_o [2];
    logic [1:0] ss_o [2];

    logic       sv0, sv1, rr0, rr1, sr0, sr1, rv0, rv1, bz0, bz1;
    logic [7:0] sval0, sval1, st0, st1, pk0, pk1;
    logic [1:0] ss0, ss1;

    assign sv0   = sv[0];
    assign sv1   = sv[1];
    assign sval0 = sval[0];
    assign sval1 = sval[1];
    assign rr0   = rr[0];
    assign rr1   = rr[1];

    always_comb begin
        sr[0] = sr0; sr[1] = sr1;
        rv[0] = rv0; rv[1] = rv1;
        bz[0] = bz0; bz[1] = bz1;
        st_o[0] = st0; st_o[1] = st1;
        pk_o[0] = pk0; pk_o[1] = pk1;
        ss_o[0] = ss0; ss_o[1] = ss1;
    end

    collatz_runner #(
        .WIDTH(8), .STEP_W(8), .MAX_STEPS(255)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .start_valid(sv0), .start_ready(sr0), .start_value(sval0),
        .result_valid(rv0), .result_ready(rr0),
        .steps(st0), .peak(pk0), .status(ss0), .busy(bz0)
    );

    collatz_runner #(
        .WIDTH(8), .STEP_W(8), .MAX_STEPS(5)
    ) dut_to (
        .clock(clock), .reset_n(reset_n),
        .start_valid(sv1), .start_ready(sr1), .start_value(sval1),
        .result_valid(rv1), .result_ready(rr1),
        .steps(st1), .peak(pk1), .status(ss1), .busy(bz1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Collatz reference: cyc counts step attempts, including the one that overflows.
    task automatic ref_model(input int unsigned n, input int unsigned lim,
                             output int unsigned s, output int unsigned pk,
                             output int unsigned st, output int unsigned cyc);
        int unsigned cur;
        int unsigned nx;
        bit          done;
        s   = 0;
        cyc = 0;
        pk  = n;
        st  = 0;
        if (n == 0) begin
            st = 2;
        end else if (n != 1) begin
            cur  = n;
            done = 1'b0;
            while (!done) begin
                cyc++;
                nx = (cur % 2 == 1) ? 3 * cur + 1 : cur / 2;
                if (nx >= Limit) begin
                    st   = 1;
                    done = 1'b1;
                end else begin
                    cur = nx;
                    s++;
                    if (cur > pk) pk = cur;
                    if (cur == 1) begin
                        st   = 0;
                        done = 1'b1;
                    end else if (s == lim) begin
                        st   = 3;
                        done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic run_one(input int u, input int unsigned val, input int hold);
        int unsigned e_steps, e_peak, e_status, e_cycles;
        int          cyc;
        ref_model(val, (u == 0) ? 255 : 5, e_steps, e_peak, e_status, e_cycles);
        check_eq("start_ready_idle", sr[u], 1);
        sv[u]   = 1'b1;
        sval[u] = val[7:0];
        @(posedge clock); #1;
        sv[u]   = 1'b0;
        sval[u] = 8'($urandom);
        if (e_cycles > 0) check_eq("busy_in_run", bz[u], 1);
        cyc = 0;
        while (!rv[u] && cyc < 600) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_eq("latency", cyc, e_cycles);
        check_eq("steps", st_o[u], e_steps);
        check_eq("peak", pk_o[u], e_peak);
        check_eq("status", ss_o[u], e_status);
        check_eq("busy_done", bz[u], 0);
        check_eq("start_ready_done", sr[u], 0);
        // Starts offered while a result is pending must be ignored.
        sv[u] = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check_eq("hold_valid", rv[u], 1);
            check_eq("hold_start_ready", sr[u], 0);
            check_eq("hold_steps", st_o[u], e_steps);
            check_eq("hold_peak", pk_o[u], e_peak);
            check_eq("hold_status", ss_o[u], e_status);
        end
        rr[u] = 1'b1;
        @(posedge clock); #1;
        rr[u] = 1'b0;
        sv[u] = 1'b0;
        check_eq("post_valid", rv[u], 0);
        check_eq("post_start_ready", sr[u], 1);
        check_eq("post_busy", bz[u], 0);
    endtask

    task automatic check_reset_vals(input int u);
        check_eq("rst_start_ready", sr[u], 1);
        check_eq("rst_result_valid", rv[u], 0);
        check_eq("rst_busy", bz[u], 0);
        check_eq("rst_steps", st_o[u], 0);
        check_eq("rst_peak", pk_o[u], 0);
        check_eq("rst_status", ss_o[u], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            sv[i]   = 1'b0;
            sval[i] = '0;
            rr[i]   = 1'b0;
        end
        #1 reset_n = 1'b0;
        #2;
        check_reset_vals(0);
        check_reset_vals(1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        run_one(0, 6, 0);
        run_one(0, 7, 5);
        run_one(0, 27, 1);
        run_one(0, 0, 0);
        run_one(0, 1, 2);
        run_one(1, 7, 0);
        run_one(0, 255, 0);
        run_one(0, 2, 0);

        // Reset in the middle of a run aborts it.
        sv[0]   = 1'b1;
        sval[0] = 8'd27;
        @(posedge clock); #1;
        sv[0] = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals(0);
        @(posedge clock); #1;
        check_reset_vals(0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_one(0, 6, 0);

        for (int i = 0; i < 60; i++) begin
            run_one(i % 2, $urandom_range(0, 255), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
